// File: rtl/gemv_pkg.sv
// Shared types and width helpers for the GEMV tile engine.
package gemv_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDrain,
    StOut
  } gemv_state_e;

  // Width of a COLS-term signed dot product without loss.
  function automatic int unsigned dot_sum_width(input int unsigned in_w,
                                                input int unsigned wt_w,
                                                input int unsigned cols);
    return in_w + wt_w + $clog2(cols);
  endfunction

  localparam int unsigned DefaultDotWidth = dot_sum_width(8, 8, 8);

endpackage

// File: rtl/gemv_row_dot.sv
// One output row: COLS-wide signed dot product, registered when en is high.
module gemv_row_dot
  import gemv_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH  = 8,
  parameter int unsigned WEIGHT_WIDTH = 8,
  parameter int unsigned COLS         = 8,
  parameter int unsigned DOT_WIDTH    = dot_sum_width(INPUT_WIDTH, WEIGHT_WIDTH, COLS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                en,
  input  logic [COLS*INPUT_WIDTH-1:0]         vec,
  input  logic [COLS*WEIGHT_WIDTH-1:0]        wts,
  output logic signed [DOT_WIDTH-1:0]         dot
);

  localparam int unsigned ProdWidth = INPUT_WIDTH + WEIGHT_WIDTH;

  logic signed [ProdWidth-1:0] prod [COLS];
  logic signed [DOT_WIDTH-1:0] sum;
  logic signed [DOT_WIDTH-1:0] dot_q;

  for (genvar c = 0; c < COLS; c++) begin : g_prod
    logic signed [INPUT_WIDTH-1:0]  a;
    logic signed [WEIGHT_WIDTH-1:0] b;
    assign a = vec[c*INPUT_WIDTH +: INPUT_WIDTH];
    assign b = wts[c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign prod[c] = ProdWidth'(a) * ProdWidth'(b);
  end

  always_comb begin
    sum = '0;
    for (int c = 0; c < COLS; c++) begin
      sum = sum + DOT_WIDTH'(prod[c]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_q <= '0;
    end else if (en) begin
      dot_q <= sum;
    end
  end

  assign dot = dot_q;

endmodule

// File: rtl/gemv_tile_engine.sv
// Tiled GEMV: accumulates num_tiles weight/activation tiles into ROWS results.
// Define GEMV_SAT_EN for saturating accumulation with a sticky overflow flag.
module gemv_tile_engine
  import gemv_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH    = 8,
  parameter int unsigned WEIGHT_WIDTH   = 8,
  parameter int unsigned ACC_WIDTH      = 32,
  parameter int unsigned ROWS           = 32,
  parameter int unsigned COLS           = 8,
  parameter int unsigned TILE_CNT_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [TILE_CNT_WIDTH-1:0]            num_tiles,
  input  logic                                 abort,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [COLS*INPUT_WIDTH-1:0]          in_vector,
  input  logic [ROWS*COLS*WEIGHT_WIDTH-1:0]    in_weights,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ROWS*ACC_WIDTH-1:0]            out_vector,
  output logic                                 busy,
  output logic                                 overflow
);

  localparam int unsigned DotWidth = dot_sum_width(INPUT_WIDTH, WEIGHT_WIDTH, COLS);
  localparam int unsigned CntExt   = TILE_CNT_WIDTH + 1;
  localparam int unsigned AccExt   = ACC_WIDTH + 1;

  if (ACC_WIDTH < DotWidth) begin : g_width_check
    $error("ACC_WIDTH is narrower than the dot-sum width");
  end

  gemv_state_e state_q, state_d;

  logic [TILE_CNT_WIDTH-1:0] num_q;
  logic [TILE_CNT_WIDTH-1:0] beat_cnt_q;
  logic [CntExt-1:0]         beat_next;
  logic                      s1_valid_q;
  logic                      accept;
  logic                      last_beat;
  logic                      start_acc;
  logic                      add_en;

  assign in_ready  = (state_q == StAccum) && (beat_cnt_q < num_q);
  // Abort outranks a handshake in the same cycle.
  assign accept    = in_valid & in_ready & ~abort;
  assign beat_next = {1'b0, beat_cnt_q} + CntExt'(1);
  assign last_beat = (beat_next == {1'b0, num_q});
  assign add_en    = s1_valid_q & ~abort;
  assign out_valid = (state_q == StOut);
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StAccum;
          start_acc = 1'b1;
        end
      end
      StAccum: begin
        if (accept && last_beat) state_d = StDrain;
      end
      StDrain: state_d = StOut;
      StOut: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (abort && (state_q != StIdle)) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      num_q      <= '0;
      beat_cnt_q <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= accept;
      if (start_acc) begin
        num_q      <= (num_tiles == '0) ? TILE_CNT_WIDTH'(1) : num_tiles;
        beat_cnt_q <= '0;
      end else if (accept) begin
        beat_cnt_q <= beat_next[TILE_CNT_WIDTH-1:0];
      end
    end
  end

`ifdef GEMV_SAT_EN
  logic [ROWS-1:0] row_ovf;
  logic            overflow_q;
`endif

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    logic signed [DotWidth-1:0]  dot;
    logic signed [ACC_WIDTH-1:0] dot_ext;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;

    gemv_row_dot #(
      .INPUT_WIDTH  (INPUT_WIDTH),
      .WEIGHT_WIDTH (WEIGHT_WIDTH),
      .COLS         (COLS),
      .DOT_WIDTH    (DotWidth)
    ) u_row_dot (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (accept),
      .vec   (in_vector),
      .wts   (in_weights[r*COLS*WEIGHT_WIDTH +: COLS*WEIGHT_WIDTH]),
      .dot   (dot)
    );

    assign dot_ext = ACC_WIDTH'(dot);

`ifdef GEMV_SAT_EN
    logic signed [AccExt-1:0] sum;
    logic                     ovf;
    assign sum = AccExt'(acc_q) + AccExt'(dot_ext);
    // Top two bits disagree only when the true sum left the ACC_WIDTH range.
    always_comb begin
      acc_d = sum[ACC_WIDTH-1:0];
      ovf   = 1'b0;
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
        ovf   = 1'b1;
        acc_d = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                               : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
    assign row_ovf[r] = ovf;
`else
    assign acc_d = acc_q + dot_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc_q <= '0;
      end else if (start_acc) begin
        acc_q <= '0;
      end else if (add_en) begin
        acc_q <= acc_d;
      end
    end

    assign out_vector[r*ACC_WIDTH +: ACC_WIDTH] = acc_q;
  end

`ifdef GEMV_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (start_acc) begin
      overflow_q <= 1'b0;
    end else if (add_en && (|row_ovf)) begin
      overflow_q <= 1'b1;
    end
  end
  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: doc/gemv_tile_engine.md
GEMV_TILE_ENGINE -- requirements
Module: gemv_tile_engine

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 8, signed activation element width.
REQ-002 SHALL have parameter WEIGHT_WIDTH, default 8, signed weight element width.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, signed accumulator/output element width.
REQ-004 SHALL have parameter ROWS, default 32, output vector length.
REQ-005 SHALL have parameter COLS, default 8, elements per input tile.
REQ-006 SHALL have parameter TILE_CNT_WIDTH, default 8, width of the tile-count field.
REQ-007 clk  input  1  clock, rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 start  input  1  job start pulse; sampled only in IDLE.
REQ-010 num_tiles  input  TILE_CNT_WIDTH  K tiles per job; latched on accepted start.
REQ-011 abort  input  1  synchronous job cancel.
REQ-012 in_valid / in_ready  input / output  1 / 1  tile beat handshake.
REQ-013 in_vector  input  COLS*INPUT_WIDTH  activation tile.
REQ-014 in_weights  input  ROWS*COLS*WEIGHT_WIDTH  weight tile, row-major.
REQ-015 out_valid / out_ready  output / input  1 / 1  result handshake.
REQ-016 out_vector  output  ROWS*ACC_WIDTH  result vector.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 overflow  output  1  sticky per-job saturation flag.

Function
REQ-019 SHALL implement FSM IDLE -> ACCUM -> DRAIN -> OUT -> IDLE.
REQ-020 IDLE: start=1 SHALL latch num_tiles, clear accumulators/overflow/beat count, go to ACCUM; num_tiles=0 SHALL be treated as 1.
REQ-021 ACCUM: in_ready SHALL be 1 while accepted beats < num_tiles, else 0; beat accepted when in_valid&in_ready.
REQ-022 Each accepted beat SHALL register per-row dot product sum_c(in_vector[c]*in_weights[r][c]) (stage 1), then add it into acc[r] next cycle (stage 2).
REQ-023 Products SHALL be signed INPUT_WIDTH+WEIGHT_WIDTH bits; dot sums INPUT_WIDTH+WEIGHT_WIDTH+clog2(COLS) bits, sign-extended to ACC_WIDTH.
REQ-024 Back-to-back beats SHALL be accepted every cycle with no bubbles.
REQ-025 Acceptance of the last beat SHALL move FSM to DRAIN; DRAIN lasts exactly 1 cycle, then OUT.
REQ-026 out_valid SHALL rise exactly 2 cycles after the last-beat acceptance edge; out_vector = acc, held stable while out_valid&!out_ready.
REQ-027 OUT: out_valid&out_ready SHALL return to IDLE next cycle; out_valid deasserts then.
REQ-028 start outside IDLE SHALL be ignored; start in the same cycle the FSM leaves OUT SHALL be ignored.
REQ-029 abort in any non-IDLE state SHALL return to IDLE next cycle, drop in_ready/out_valid, discard in-flight stage-1 data; abort has priority over all handshakes in that cycle.
REQ-030 overflow SHALL be 0 whenever GEMV_SAT_EN is undefined.

Reset
REQ-031 rst_n low SHALL asynchronously force IDLE; in_ready, out_valid, busy, overflow = 0; out_vector, accumulators, pipeline registers = 0.
REQ-032 Reset mid-job SHALL discard the job; no output is produced for it.

Configuration
REQ-033 With GEMV_SAT_EN defined, stage-2 addition SHALL clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1] and set overflow (sticky until next accepted start).
REQ-034 Without GEMV_SAT_EN, accumulation SHALL wrap modulo 2^ACC_WIDTH.

Structure
REQ-035 Shared package gemv_pkg SHALL hold the FSM state enum and the clog2-derived dot-sum width function/constant.
REQ-036 One sub-module gemv_row_dot SHALL compute and register one row's COLS-wide signed dot product; ROWS instances.
REQ-037 Elaboration SHALL fail if ACC_WIDTH < INPUT_WIDTH+WEIGHT_WIDTH+clog2(COLS).

Verification
REQ-038 num_tiles=1, all inputs 1, all weights 2 -> each out_vector element = 16, out_valid 2 cycles after acceptance.
REQ-039 num_tiles=4, beats back-to-back, inputs -3, weights 5 -> each element = -480; in_ready low after 4th beat.
REQ-040 out_ready held 0 for 5 cycles -> out_vector stable, out_valid high, in_ready 0, start ignored.
REQ-041 abort during beat 2 of 4 -> IDLE next cycle, no out_valid; next job num_tiles=1 (inputs 1, weights 1) yields exactly 8.
REQ-042 GEMV_SAT_EN, ACC_WIDTH=20, num_tiles=255, inputs 127, weights 127 -> elements = 524287, overflow=1; without macro result wraps, overflow=0.
REQ-043 rst_n asserted mid-ACCUM -> all outputs 0 immediately; num_tiles=0 job afterwards behaves as 1 tile.
